// File: rtl/mux_sel_arbiter8.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter8
//   Round-robin arbiter that shares one 8:1 datapath mux (and the resource
//   behind it) among 8 requesters. The arbiter registers a one-hot grant and
//   the matching 3-bit select code for the mux. An owner that keeps the grant
//   while others are waiting is revoked after MAX_HOLD cycles. Every change of
//   owner goes through a one-cycle turnaround (GAP) with no grant.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles for one owner while another
//              requester is waiting (legal range 1..255)
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   req      in   8  request vector, held high by a requester while it owns
//   grant    out  8  registered one-hot grant, zero when nobody owns
//   sel      out  3  index of the current or most recent owner (mux select)
//   busy     out  1  an owner currently holds the grant
//   forced   out  1  one-cycle pulse on the cycle after a timeout revoke
// ---------------------------------------------------------------------------
module mux_sel_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       forced
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 8;

    // Terminal value of the hold counter; the counter saturates here.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [SEL_W-1:0]   r_sel;
    logic               r_busy;
    logic               r_forced;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [SEL_W-1:0]   r_last_ptr;

    logic               w_pick_valid;
    logic [SEL_W-1:0]   w_pick_idx;
    logic [SEL_W-1:0]   w_scan_idx;
    logic               w_owner_req;
    logic               w_others_req;
    logic               w_hold_max;

    // Round-robin pick: scan from last_ptr+1 upward with wrap. The loop runs
    // from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_scan_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_scan_idx = r_last_ptr + SEL_W'(k + 1);
            if (req[w_scan_idx]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_scan_idx;
            end
        end
    end

    // While holding, r_grant is exactly the owner's one-hot mask.
    assign w_owner_req  = |(req & r_grant);
    assign w_others_req = |(req & ~r_grant);
    assign w_hold_max   = (r_hold_cnt == HOLD_LAST);

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_sel      <= '0;
            r_busy     <= 1'b0;
            r_forced   <= 1'b0;
            r_hold_cnt <= '0;
            r_last_ptr <= SEL_W'(N_REQ - 1);
        end else begin
            r_forced <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant    <= N_REQ'(1) << w_pick_idx;
                        r_sel      <= w_pick_idx;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                        r_last_ptr <= w_pick_idx;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A normal release takes precedence over a timeout.
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_GAP;
                    end else if (w_hold_max && w_others_req) begin
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                        r_forced <= 1'b1;
                        r_state  <= ST_GAP;
                    end else if (!w_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // Mux turnaround; arbitration resumes in IDLE.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant  = r_grant;
    assign sel    = r_sel;
    assign busy   = r_busy;
    assign forced = r_forced;

    // Structural invariants of the grant outputs.
    a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(r_grant));
    a_sel_matches: assert property (@(posedge clk) disable iff (!reset_n)
        r_busy |-> (r_grant == (N_REQ'(1) << r_sel)));
    a_forced_idle: assert property (@(posedge clk) disable iff (!reset_n)
        r_forced |-> !r_busy);

endmodule

// File: tb/tb_mux_sel_arbiter8.sv
module tb_mux_sel_arbiter8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] req;

    logic [7:0] g4,  g16;
    logic [2:0] s4,  s16;
    logic       b4,  b16;
    logic       f4,  f16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(g4), .sel(s4), .busy(b4), .forced(f4)
    );

    mux_sel_arbiter8 #(.MAX_HOLD(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(g16), .sel(s16), .busy(b16), .forced(f16)
    );

    wire [12:0] obs4  = {g4,  s4,  b4,  f4};
    wire [12:0] obs16 = {g16, s16, b16, f16};

    // Reference model: index 0 mirrors MAX_HOLD=4, index 1 MAX_HOLD=16.
    int         mh[2]      = '{4, 16};
    int         m_owner[2] = '{-1, -1};
    int         m_last[2]  = '{7, 7};
    int         m_held[2]  = '{0, 0};
    bit         m_gap[2]   = '{0, 0};
    logic [2:0] m_sel[2]   = '{3'd0, 3'd0};
    logic       m_forced[2] = '{1'b0, 1'b0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_last[k] = 7; m_held[k] = 0;
            m_gap[k] = 0; m_sel[k] = 3'd0; m_forced[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] r);
        for (int k = 0; k < 2; k++) begin
            m_forced[k] = 1'b0;
            if (m_owner[k] >= 0) begin
                if (!r[m_owner[k]]) begin
                    m_owner[k] = -1; m_gap[k] = 1;
                end else if (m_held[k] == mh[k] - 1 &&
                             (r & ~(8'(1) << m_owner[k])) != 8'h00) begin
                    m_owner[k] = -1; m_gap[k] = 1; m_forced[k] = 1'b1;
                end else if (m_held[k] < mh[k] - 1) begin
                    m_held[k]++;
                end
            end else if (m_gap[k]) begin
                m_gap[k] = 0;
            end else if (r != 8'h00) begin
                for (int d = 1; d <= 8; d++) begin
                    int i;
                    i = (m_last[k] + d) % 8;
                    if (r[i]) begin
                        m_owner[k] = i; m_last[k] = i; m_sel[k] = 3'(i);
                        m_held[k] = 0;
                        break;
                    end
                end
            end
        end
    endtask

    function automatic logic [12:0] exp_vec(input int k);
        logic [7:0] g;
        g = (m_owner[k] < 0) ? 8'h00 : (8'(1) << m_owner[k]);
        return {g, m_sel[k], (m_owner[k] >= 0), m_forced[k]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step(req);
    end

    function automatic int oh_index(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        req = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 8'hFF;
        #2;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs4 !== 13'h0) begin
                failures++; $display("FAIL reset_dut4 got=%h exp=%h", obs4, 13'h0);
            end
            checks++;
            if (obs16 !== 13'h0) begin
                failures++; $display("FAIL reset_dut16 got=%h exp=%h", obs16, 13'h0);
            end
        end
        req = 8'h00;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h04;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs4 !== exp_vec(0)) begin
                failures++; $display("FAIL single_model4 c=%0d got=%h exp=%h", c, obs4, exp_vec(0));
            end
            checks++;
            if (obs16 !== exp_vec(1)) begin
                failures++; $display("FAIL single_model16 c=%0d got=%h exp=%h", c, obs16, exp_vec(1));
            end
            checks++;
            if (c <= 5) begin
                if ({g16, s16, b16} !== {8'h04, 3'd2, 1'b1}) begin
                    failures++; $display("FAIL single_grant c=%0d got=%h/%0d/%b exp=04/2/1", c, g16, s16, b16);
                end
            end else begin
                if ({g16, s16, b16} !== {8'h00, 3'd2, 1'b0}) begin
                    failures++; $display("FAIL single_gap c=%0d got=%h/%0d/%b exp=00/2/0", c, g16, s16, b16);
                end
            end
            if (c == 5) req = 8'h00;
        end
    endtask

    task automatic test_fairness();
        int n_grants = 0;
        int hold_len = 0;
        int gap_len  = 0;
        logic [7:0] prev = 8'h00;
        do_reset();
        req = 8'hFF;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            checks++;
            if (obs4 !== exp_vec(0)) begin
                failures++; $display("FAIL fair_model4 c=%0d got=%h exp=%h", c, obs4, exp_vec(0));
            end
            checks++;
            if (obs16 !== exp_vec(1)) begin
                failures++; $display("FAIL fair_model16 c=%0d got=%h exp=%h", c, obs16, exp_vec(1));
            end
            if (g4 != 8'h00 && prev == 8'h00) begin
                checks++;
                if (oh_index(g4) !== (n_grants % 8)) begin
                    failures++; $display("FAIL fair_order n=%0d got=%0d exp=%0d", n_grants, oh_index(g4), n_grants % 8);
                end
                if (n_grants > 0) begin
                    checks++;
                    if (gap_len !== 2) begin
                        failures++; $display("FAIL fair_gap n=%0d got=%0d exp=2", n_grants, gap_len);
                    end
                end
                n_grants++;
                hold_len = 0;
            end
            if (g4 == 8'h00 && prev != 8'h00) begin
                checks++;
                if (hold_len !== 4 || f4 !== 1'b1) begin
                    failures++; $display("FAIL fair_revoke n=%0d hold=%0d forced=%b exp=4/1", n_grants, hold_len, f4);
                end
                gap_len = 0;
            end
            if (g4 != 8'h00) hold_len++;
            else             gap_len++;
            prev = g4;
        end
        checks++;
        if (n_grants !== 10) begin
            failures++; $display("FAIL fair_count got=%0d exp=10", n_grants);
        end
        req = 8'h00;
    endtask

    task automatic test_priority_after_release();
        do_reset();
        req = 8'h40;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs4 !== exp_vec(0)) begin
                failures++; $display("FAIL prio_model4 c=%0d got=%h exp=%h", c, obs4, exp_vec(0));
            end
            checks++;
            if (obs16 !== exp_vec(1)) begin
                failures++; $display("FAIL prio_model16 c=%0d got=%h exp=%h", c, obs16, exp_vec(1));
            end
            if (c == 1) begin
                checks++;
                if (g16 !== 8'h40) begin
                    failures++; $display("FAIL prio_first got=%h exp=40", g16);
                end
            end
            if (c == 6) begin
                checks++;
                if (g16 !== 8'h01 || s16 !== 3'd0) begin
                    failures++; $display("FAIL prio_wrap got=%h/%0d exp=01/0", g16, s16);
                end
            end
            case (c)
                1: req = 8'h41;
                3: req = 8'h01;
                4: req = 8'h41;
                default: ;
            endcase
        end
        req = 8'h00;
    endtask

    task automatic test_sole();
        do_reset();
        req = 8'h80;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if (obs16 !== exp_vec(1)) begin
                failures++; $display("FAIL sole_model16 c=%0d got=%h exp=%h", c, obs16, exp_vec(1));
            end
            checks++;
            if ({g4, f4, g16, f16} !== {8'h80, 1'b0, 8'h80, 1'b0}) begin
                failures++; $display("FAIL sole_hold c=%0d got=%h/%b %h/%b exp=80/0", c, g4, f4, g16, f16);
            end
        end
        checks++;
        if (u_dut16.r_hold_cnt !== 8'd15) begin
            failures++; $display("FAIL sole_sat16 got=%0d exp=15", u_dut16.r_hold_cnt);
        end
        checks++;
        if (u_dut4.r_hold_cnt !== 8'd3) begin
            failures++; $display("FAIL sole_sat4 got=%0d exp=3", u_dut4.r_hold_cnt);
        end
        req = 8'h00;
    endtask

    task automatic test_collision();
        do_reset();
        req = 8'h08;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs4 !== exp_vec(0)) begin
                failures++; $display("FAIL coll_model4 c=%0d got=%h exp=%h", c, obs4, exp_vec(0));
            end
            checks++;
            if (obs16 !== exp_vec(1)) begin
                failures++; $display("FAIL coll_model16 c=%0d got=%h exp=%h", c, obs16, exp_vec(1));
            end
            checks++;
            if (f4 !== 1'b0) begin
                failures++; $display("FAIL coll_forced c=%0d got=%b exp=0", c, f4);
            end
            if (c == 5) begin
                checks++;
                if ({g4, b4} !== {8'h00, 1'b0}) begin
                    failures++; $display("FAIL coll_release got=%h/%b exp=00/0", g4, b4);
                end
            end
            if (c == 7) begin
                checks++;
                if ({g4, s4} !== {8'h20, 3'd5}) begin
                    failures++; $display("FAIL coll_next got=%h/%0d exp=20/5", g4, s4);
                end
            end
            case (c)
                1: req = 8'h28;
                4: req = 8'h20;
                default: ;
            endcase
        end
        req = 8'h00;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h10;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({g4, s4, b4, f4, g16, s16, b16, f16} !== 26'h0) begin
            failures++; $display("FAIL async_drop got=%h/%h exp=0/0", obs4, obs16);
        end
        req = 8'h81;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs4 !== exp_vec(0) || obs16 !== exp_vec(1)) begin
                failures++; $display("FAIL async_model c=%0d got=%h/%h exp=%h/%h", c, obs4, obs16, exp_vec(0), exp_vec(1));
            end
            if (c == 1) begin
                checks++;
                if ({g4, s4, g16, s16} !== {8'h01, 3'd0, 8'h01, 3'd0}) begin
                    failures++; $display("FAIL async_regrant got=%h/%0d %h/%0d exp=01/0", g4, s4, g16, s16);
                end
            end
        end
        req = 8'h00;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            checks++;
            if (obs4 !== exp_vec(0)) begin
                failures++; $display("FAIL rand_model4 c=%0d req=%h got=%h exp=%h", c, req, obs4, exp_vec(0));
            end
            checks++;
            if (obs16 !== exp_vec(1)) begin
                failures++; $display("FAIL rand_model16 c=%0d req=%h got=%h exp=%h", c, req, obs16, exp_vec(1));
            end
            // Each bit toggles with probability 1/8 so requests persist.
            req = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        end
        req = 8'h00;
    endtask

    initial begin
        reset_n = 1'b0;
        req = 8'h00;
        test_reset();
        test_single();
        test_fairness();
        test_priority_after_release();
        test_sole();
        test_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
